// File: rtl/dfifo_pkg.sv
// -----------------------------------------------------------------------------
// dfifo_pkg
// Shared constants and helpers for the dfifo block.
//   MODE_FALL_THROUGH / MODE_REGISTERED : legal values of the dfifo MODE param.
//   ptr_width()                         : index width for a DEPTH-entry store,
//                                         never narrower than one bit.
// -----------------------------------------------------------------------------
package dfifo_pkg;

    localparam int MODE_FALL_THROUGH = 0;
    localparam int MODE_REGISTERED   = 1;

    // $clog2(1) is 0, which would give a zero-width pointer for DEPTH=1.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dti.sv
// -----------------------------------------------------------------------------
// dti
// Generic valid/ready data channel.
//   valid : producer has a word on data this cycle
//   ready : consumer can take a word this cycle
//   data  : payload, W bits
// Handshake: a word moves exactly in a cycle where valid and ready are both
// high at the rising clock edge. A producer keeps valid/data stable until the
// word moves; ready may change freely and never gates valid.
// -----------------------------------------------------------------------------
interface dti #(
    parameter int W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/dfifo_mem.sv
// -----------------------------------------------------------------------------
// dfifo_mem
// DEPTH x W storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write index (0..DEPTH-1)
//   wdata_i : write data
//   raddr_i : read index (0..DEPTH-1)
//   rdata_o : combinational read data
// -----------------------------------------------------------------------------
module dfifo_mem #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    parameter int AW    = 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dfifo.sv
// -----------------------------------------------------------------------------
// dfifo
// Single-clock FIFO with arbitrary (non power-of-two) depth, optional
// fall-through bypass, flush and almost-full flag.
//   clk         : clock, all state on rising edge
//   rst         : synchronous active-high reset, beats flush and transfers
//   flush       : synchronous discard of all stored entries
//   din         : upstream channel (consumer side), din.ready = ~full
//   dout        : downstream channel (producer side)
//   count       : registered occupancy, 0..DEPTH
//   almost_full : registered, count >= AFULL_THR
// -----------------------------------------------------------------------------
module dfifo
    import dfifo_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int MODE      = 1,
    parameter int AFULL_THR = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    dti.consumer                       din,
    dti.producer                       dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int W_DATA = $bits(din.data);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int PW     = ptr_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    if (DEPTH < 1) begin : g_err_depth
        $error("dfifo: DEPTH must be >= 1");
    end
    if (MODE != MODE_FALL_THROUGH && MODE != MODE_REGISTERED) begin : g_err_mode
        $error("dfifo: MODE must be 0 or 1");
    end
    if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_err_afull
        $error("dfifo: AFULL_THR must be within 1..DEPTH");
    end
    if ($bits(din.data) != $bits(dout.data)) begin : g_err_width
        $error("dfifo: din and dout data widths differ");
    end

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              afull_q, afull_d;

    logic              full, empty;
    logic              bypass, bypass_xfer;
    logic              out_valid;
    logic              push, pop, mem_we;
    logic [W_DATA-1:0] rd_data;

    always_comb begin
        full  = (count_q == DEPTH_C);
        empty = (count_q == '0);

        // Fall-through: an empty FIFO presents the incoming word directly.
        bypass    = (MODE == MODE_FALL_THROUGH) && empty && din.valid;
        out_valid = !rst && !flush && (!empty || bypass);

        // A bypassed word taken downstream the same cycle never touches
        // storage; it counts as neither a push nor a pop.
        bypass_xfer = bypass && out_valid && dout.ready;
        push        = din.valid && !full && !bypass_xfer;
        pop         = out_valid && dout.ready && !bypass_xfer;
        mem_we      = push && !flush && !rst;
    end

    assign din.ready   = !full;
    assign dout.valid  = out_valid;
    assign dout.data   = bypass ? din.data : rd_data;
    assign count       = count_q;
    assign almost_full = afull_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Explicit wrap compare keeps non power-of-two depths correct.
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        afull_d = (count_d >= AFULL_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
        end
    end

    dfifo_mem #(
        .DEPTH (DEPTH),
        .W     (W_DATA),
        .AW    (PW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (din.data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_dfifo.sv
// -----------------------------------------------------------------------------
// tb_dfifo
// Three dfifo instances sharing clock, reset and flush:
//   u_a : DEPTH=3, MODE=1, 8-bit  (fill/drain, flush, mid-run reset)
//   u_b : DEPTH=5, MODE=1, 16-bit (random valid/ready stream of 1000 words)
//   u_c : DEPTH=4, MODE=0, 8-bit  (bypass, full with concurrent read)
// Per-instance monitors record accepted input words into an expected queue
// and compare every delivered output word against the queue head.
// -----------------------------------------------------------------------------
module tb_dfifo;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush;

    int checks   = 0;
    int failures = 0;

    dti #(.W(8))  a_in ();
    dti #(.W(8))  a_out ();
    dti #(.W(16)) b_in ();
    dti #(.W(16)) b_out ();
    dti #(.W(8))  c_in ();
    dti #(.W(8))  c_out ();

    logic [1:0] a_count;
    logic [2:0] b_count;
    logic [2:0] c_count;
    logic       a_af, b_af, c_af;

    dfifo #(.DEPTH(3), .MODE(1)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .din(a_in), .dout(a_out),
        .count(a_count), .almost_full(a_af)
    );
    dfifo #(.DEPTH(5), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .din(b_in), .dout(b_out),
        .count(b_count), .almost_full(b_af)
    );
    dfifo #(.DEPTH(4), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .din(c_in), .dout(c_out),
        .count(c_count), .almost_full(c_af)
    );

    // ---------------- scoreboard ----------------
    logic [7:0]  a_exp_q[$];
    logic [15:0] b_exp_q[$];
    logic [7:0]  c_exp_q[$];
    int          b_got       = 0;
    logic        b_full_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst || flush) begin
            a_exp_q.delete();
        end else begin
            if (a_in.valid && a_in.ready) a_exp_q.push_back(a_in.data);
            if (a_out.valid && a_out.ready) begin
                if (a_exp_q.size() == 0) begin
                    chk("a_unexpected_out", 32'(a_out.data), 32'hDEAD_BEEF);
                end else begin
                    e = a_exp_q.pop_front();
                    chk("a_order", 32'(a_out.data), 32'(e));
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (b_count == 3'd5) b_full_seen = 1'b1;
        if (rst || flush) begin
            b_exp_q.delete();
        end else begin
            if (b_in.valid && b_in.ready) b_exp_q.push_back(b_in.data);
            if (b_out.valid && b_out.ready) begin
                b_got++;
                if (b_exp_q.size() == 0) begin
                    chk("b_unexpected_out", 32'(b_out.data), 32'hDEAD_BEEF);
                end else begin
                    e = b_exp_q.pop_front();
                    chk("b_order", 32'(b_out.data), 32'(e));
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst || flush) begin
            c_exp_q.delete();
        end else begin
            if (c_in.valid && c_in.ready) c_exp_q.push_back(c_in.data);
            if (c_out.valid && c_out.ready) begin
                if (c_exp_q.size() == 0) begin
                    chk("c_unexpected_out", 32'(c_out.data), 32'hDEAD_BEEF);
                end else begin
                    e = c_exp_q.pop_front();
                    chk("c_order", 32'(c_out.data), 32'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [7:0] d);
        a_in.valid = 1'b1;
        a_in.data  = d;
        step();
        a_in.valid = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int idx;
        int cyc;
        logic took;

        rst = 1'b1;
        flush = 1'b0;
        a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
        c_in.valid = 1'b0; c_in.data = '0; c_out.ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_a_count", 32'(a_count), 0);
        chk("rst_a_af", 32'(a_af), 0);
        chk("rst_a_in_ready", 32'(a_in.ready), 1);
        chk("rst_a_out_valid", 32'(a_out.valid), 0);
        chk("rst_b_count", 32'(b_count), 0);
        chk("rst_c_count", 32'(c_count), 0);
        rst = 1'b0;

        // C: fall-through bypass when empty
        c_out.ready = 1'b1;
        c_in.valid  = 1'b1;
        c_in.data   = 8'hA5;
        #1;
        chk("c_bypass_valid", 32'(c_out.valid), 1);
        chk("c_bypass_data", 32'(c_out.data), 32'h A5);
        step();
        c_in.valid = 1'b0;
        chk("c_bypass_count", 32'(c_count), 0);

        // C: fill to full, then one cycle of read with write attempted
        c_out.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c_in.valid = 1'b1;
            c_in.data  = 8'(8'hC1 + i);
            step();
        end
        c_in.valid = 1'b0;
        chk("c_full_count", 32'(c_count), 4);
        chk("c_full_in_ready", 32'(c_in.ready), 0);
        chk("c_full_af", 32'(c_af), 1);
        c_in.valid  = 1'b1;
        c_in.data   = 8'hEE;
        c_out.ready = 1'b1;
        step();
        c_in.valid  = 1'b0;
        c_out.ready = 1'b0;
        chk("c_full_read_count", 32'(c_count), 3);
        chk("c_full_read_in_ready", 32'(c_in.ready), 1);
        c_out.ready = 1'b1;
        repeat (3) step();
        c_out.ready = 1'b0;
        chk("c_drained_count", 32'(c_count), 0);

        // A: registered fill with output stalled
        a_out.ready = 1'b0;
        a_in.valid  = 1'b1;
        a_in.data   = 8'h11;
        #1;
        chk("a_no_same_cycle_valid", 32'(a_out.valid), 0);
        step();
        chk("a_fill1_count", 32'(a_count), 1);
        chk("a_fill1_af", 32'(a_af), 0);
        chk("a_fill1_out_data", 32'(a_out.data), 32'h11);
        a_in.data = 8'h22;
        step();
        chk("a_fill2_count", 32'(a_count), 2);
        chk("a_fill2_af", 32'(a_af), 1);
        chk("a_fill2_in_ready", 32'(a_in.ready), 1);
        a_in.data = 8'h33;
        step();
        a_in.valid = 1'b0;
        chk("a_fill3_count", 32'(a_count), 3);
        chk("a_fill3_in_ready", 32'(a_in.ready), 0);
        chk("a_fill3_af", 32'(a_af), 1);
        a_out.ready = 1'b1;
        repeat (3) step();
        a_out.ready = 1'b0;
        chk("a_drain_count", 32'(a_count), 0);
        chk("a_drain_af", 32'(a_af), 0);
        chk("a_drain_out_valid", 32'(a_out.valid), 0);

        // A: flush at count 2 with a concurrent push
        a_push(8'h01);
        a_push(8'h02);
        chk("a_preflush_count", 32'(a_count), 2);
        flush       = 1'b1;
        a_in.valid  = 1'b1;
        a_in.data   = 8'h7E;
        a_out.ready = 1'b1;
        #1;
        chk("a_flush_out_valid", 32'(a_out.valid), 0);
        step();
        flush      = 1'b0;
        a_in.valid = 1'b0;
        chk("a_postflush_count", 32'(a_count), 0);
        chk("a_postflush_af", 32'(a_af), 0);
        chk("a_postflush_out_valid", 32'(a_out.valid), 0);
        a_out.ready = 1'b0;
        a_push(8'h44);
        a_out.ready = 1'b1;
        step();
        a_out.ready = 1'b0;
        chk("a_after_flush_count", 32'(a_count), 0);

        // A: reset at count 3 together with flush and transfers
        a_push(8'h51);
        a_push(8'h52);
        a_push(8'h53);
        chk("a_prerst_count", 32'(a_count), 3);
        rst         = 1'b1;
        flush       = 1'b1;
        a_in.valid  = 1'b1;
        a_in.data   = 8'h99;
        a_out.ready = 1'b1;
        c_in.valid  = 1'b1;
        c_in.data   = 8'h77;
        c_out.ready = 1'b1;
        #1;
        chk("a_in_rst_out_valid", 32'(a_out.valid), 0);
        chk("c_in_rst_out_valid", 32'(c_out.valid), 0);
        step();
        rst         = 1'b0;
        flush       = 1'b0;
        a_in.valid  = 1'b0;
        a_out.ready = 1'b0;
        c_in.valid  = 1'b0;
        c_out.ready = 1'b0;
        chk("a_postrst_count", 32'(a_count), 0);
        chk("a_postrst_af", 32'(a_af), 0);
        chk("a_postrst_in_ready", 32'(a_in.ready), 1);
        chk("c_postrst_count", 32'(c_count), 0);
        a_push(8'h61);
        chk("a_postrst_first_valid", 32'(a_out.valid), 1);
        chk("a_postrst_first_data", 32'(a_out.data), 32'h61);
        a_out.ready = 1'b1;
        step();
        a_out.ready = 1'b0;
        chk("a_postrst_final_count", 32'(a_count), 0);

        // B: random valid/ready stream, 1000 words, slow drain early on
        idx = 0;
        cyc = 0;
        while ((idx < 1000 || b_got < 1000) && cyc < 20000) begin
            b_in.valid  = (idx < 1000) && ($urandom_range(0, 3) != 0);
            b_in.data   = 16'(idx);
            b_out.ready = (cyc < 200) ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = b_in.valid && b_in.ready;
            step();
            if (took) idx++;
            cyc++;
        end
        b_in.valid  = 1'b0;
        b_out.ready = 1'b0;
        chk("b_within_budget", 32'(cyc < 20000), 1);
        chk("b_words_in", 32'(idx), 1000);
        chk("b_words_out", 32'(b_got), 1000);
        chk("b_reached_full", 32'(b_full_seen), 1);
        chk("b_final_count", 32'(b_count), 0);
        chk("b_queue_empty", 32'(b_exp_q.size()), 0);
        chk("a_queue_empty", 32'(a_exp_q.size()), 0);
        chk("c_queue_empty", 32'(c_exp_q.size()), 0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
